// File: rtl/sat_pkg.sv
// Shared types and helpers for the saturating/rounding pipeline
// (sat_round_pipe, sat_round_lane).
package sat_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC      = 2'd0,
        RND_HALF_UP    = 2'd1,
        RND_CONVERGENT = 2'd2,
        RND_RSVD       = 2'd3
    } round_mode_t;

    function automatic longint max_val(input int ow);
        return (longint'(1) << (ow - 1)) - longint'(1);
    endfunction

    // The symmetric range gives up the most negative code so that |min| == max.
    function automatic longint min_val(input int ow, input int sym);
        return (sym != 0) ? -max_val(ow) : -(longint'(1) << (ow - 1));
    endfunction

endpackage

// File: rtl/sat_round_lane.sv
// One channel: stage-1 rounding shift, stage-2 saturation, sticky flag and,
// when SAT_ROUND_PIPE_STATS_EN is defined, a saturating event counter.
module sat_round_lane
    import sat_pkg::*;
#(
    parameter int IW        = 16,
    parameter int OW        = 8,
    parameter int SHIFT     = 4,
    parameter int SYMMETRIC = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_p1_i,
    input  logic             en_p2_i,
    input  logic             vld_p2_i,
    input  logic             clr_i,
    input  logic [IW-1:0]    x_i,
    input  logic [1:0]       mode_i,
    output logic [OW-1:0]    y_o,
    output logic             sat_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int RW = IW - SHIFT + 1;
    localparam logic [IW:0] HALF = (SHIFT > 0) ? ((IW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic [IW:0] MASK = ~({(IW+1){1'b1}} << SHIFT);
    localparam logic signed [RW-1:0] MAXV = RW'(max_val(OW));
    localparam logic signed [RW-1:0] MINV = RW'(min_val(OW, SYMMETRIC));

    function automatic logic signed [RW-1:0] round_fn(input logic signed [IW-1:0] x,
                                                       input round_mode_t m);
        logic signed [IW:0] xe;
        logic signed [IW:0] t_full;
        logic signed [IW:0] h_full;
        logic        [IW:0] frac;
        // One guard bit above IW keeps x + HALF from wrapping.
        xe     = {x[IW-1], x};
        t_full = xe >>> SHIFT;
        h_full = (xe + $signed(HALF)) >>> SHIFT;
        frac   = xe & MASK;
        if (SHIFT == 0) return t_full[RW-1:0];
        case (m)
            RND_HALF_UP:    return h_full[RW-1:0];
            RND_CONVERGENT: return (frac == HALF && !t_full[0]) ? t_full[RW-1:0] : h_full[RW-1:0];
            default:        return t_full[RW-1:0];
        endcase
    endfunction

    function automatic logic [OW:0] sat_fn(input logic signed [RW-1:0] r);
        if (r > MAXV)      return {1'b1, MAXV[OW-1:0]};
        else if (r < MINV) return {1'b1, MINV[OW-1:0]};
        else               return {1'b0, r[OW-1:0]};
    endfunction

    logic signed [RW-1:0] r_p1_q, r_p1_d;
    logic [OW:0]          ys_p2_d;
    logic [OW-1:0]        y_p2_q;
    logic                 sat_p2_q;
    logic                 sticky_q, sticky_d;

    assign r_p1_d  = round_fn($signed(x_i), round_mode_t'(mode_i));
    assign ys_p2_d = sat_fn(r_p1_q);

    // Stage 1: rounding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_p1_q <= '0;
        else if (en_p1_i) r_p1_q <= r_p1_d;
    end

    // Stage 2: saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p2_q   <= '0;
            sat_p2_q <= 1'b0;
        end else if (en_p2_i) begin
            y_p2_q   <= ys_p2_d[OW-1:0];
            sat_p2_q <= ys_p2_d[OW];
        end
    end

    assign sticky_d = clr_i ? 1'b0 : (sticky_q | (vld_p2_i & sat_p2_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

`ifdef SAT_ROUND_PIPE_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                                      cnt_d = '0;
        else if (vld_p2_i && sat_p2_q && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

    assign y_o      = y_p2_q;
    assign sat_o    = sat_p2_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/sat_round_pipe.sv
// N-channel 2-cycle round-and-saturate pipeline with shared valid chain.
// Optional per-channel saturation counters: define SAT_ROUND_PIPE_STATS_EN.
module sat_round_pipe
    import sat_pkg::*;
#(
    parameter int N         = 2,
    parameter int IW        = 16,
    parameter int OW        = 8,
    parameter int SHIFT     = 4,
    parameter int SYMMETRIC = 0,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic [N*IW-1:0]    x_i,
    input  logic [1:0]         mode_i,
    input  logic               clr_i,
    output logic               valid_o,
    output logic [N*OW-1:0]    y_o,
    output logic [N-1:0]       sat_o,
    output logic [N-1:0]       sticky_o,
    output logic [N*CNT_W-1:0] sat_cnt_o
);
    logic vld_p1_q;
    logic vld_p2_q;

    // Stage 1 / stage 2 valid chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= valid_i;
            vld_p2_q <= vld_p1_q;
        end
    end

    assign valid_o = vld_p2_q;

    for (genvar k = 0; k < N; k++) begin : g_lane
        sat_round_lane #(
            .IW        (IW),
            .OW        (OW),
            .SHIFT     (SHIFT),
            .SYMMETRIC (SYMMETRIC),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_p1_i  (valid_i),
            .en_p2_i  (vld_p1_q),
            .vld_p2_i (vld_p2_q),
            .clr_i    (clr_i),
            .x_i      (x_i[k*IW +: IW]),
            .mode_i   (mode_i),
            .y_o      (y_o[k*OW +: OW]),
            .sat_o    (sat_o[k]),
            .sticky_o (sticky_o[k]),
            .cnt_o    (sat_cnt_o[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_sat_round_pipe.sv
// Scoreboard bench for sat_round_pipe (N=2, IW=16, OW=8, SHIFT=4, CNT_W=8).
module tb_sat_round_pipe;
    localparam int N = 2, IW = 16, OW = 8, SHIFT = 4, SYM = 0, CNT_W = 8;
    localparam logic [7:0] NEG_CLIP = (SYM != 0) ? 8'h81 : 8'h80;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_i;
    logic [N*IW-1:0]   x_i;
    logic [1:0]        mode_i;
    logic              clr_i;
    logic              valid_o;
    logic [N*OW-1:0]   y_o;
    logic [N-1:0]      sat_o;
    logic [N-1:0]      sticky_o;
    logic [N*CNT_W-1:0] sat_cnt_o;

    sat_round_pipe #(.N(N), .IW(IW), .OW(OW), .SHIFT(SHIFT), .SYMMETRIC(SYM), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .x_i(x_i), .mode_i(mode_i),
        .clr_i(clr_i), .valid_o(valid_o), .y_o(y_o), .sat_o(sat_o),
        .sticky_o(sticky_o), .sat_cnt_o(sat_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        logic [1:0]  s;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   nout = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per presented output
    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            exp_t e;
            nout++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got valid_o=1 y_o=%h expected no output", y_o);
            end else begin
                e = q.pop_front();
                chk("y_o", 64'(y_o), 64'(e.y));
                chk("sat_o", 64'(sat_o), 64'(e.s));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at posedge+#1; the sample is captured on the next edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                         input logic [7:0] ya, input logic [7:0] yb,
                         input logic sa, input logic sb);
        exp_t e;
        valid_i = 1'b1;
        x_i     = {b, a};
        mode_i  = m;
        e.y = {yb, ya};
        e.s = {sb, sa};
        e.cyc = cyc + 2;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clr_pulse();
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: got no valid_o within 10 cycles expected valid_o=1");
        end
    endtask

    initial begin
        bit ok;
        int seen;
        rst_n = 1'b0; valid_i = 1'b0; x_i = '0; mode_i = 2'd0; clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_y_o", 64'(y_o), 64'd0);
        chk("rst_sat_o", 64'(sat_o), 64'd0);
        chk("rst_sticky_o", 64'(sticky_o), 64'd0);
        chk("rst_sat_cnt_o", 64'(sat_cnt_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Rounding vectors, back to back
        issue(16'h0018, 16'h0028, 2'd0, 8'h01, 8'h02, 0, 0);
        issue(16'h0018, 16'h0028, 2'd1, 8'h02, 8'h03, 0, 0);
        issue(16'h0018, 16'h0028, 2'd2, 8'h02, 8'h02, 0, 0);
        issue(16'hFFE8, 16'hFFE8, 2'd0, 8'hFE, 8'hFE, 0, 0);
        issue(16'hFFE8, 16'hFFE8, 2'd1, 8'hFF, 8'hFF, 0, 0);
        issue(16'hFFE8, 16'hFFE8, 2'd2, 8'hFE, 8'hFE, 0, 0);
        issue(16'hFFD8, 16'h0038, 2'd2, 8'hFE, 8'h04, 0, 0);
        issue(16'h0018, 16'h0028, 2'd3, 8'h01, 8'h02, 0, 0);
        idle(4);
        chk("sticky_no_sat", 64'(sticky_o), 64'd0);

        // Clipping
        issue(16'h7FFF, 16'h8000, 2'd0, 8'h7F, NEG_CLIP, 1, 1);
        idle(4);
        chk("sticky_clip", 64'(sticky_o), 64'd3);
        clr_pulse();
        chk("sticky_clr", 64'(sticky_o), 64'd0);

        // Rounding-induced overflow
        issue(16'h07F8, 16'h0000, 2'd1, 8'h7F, 8'h00, 1, 0);
        issue(16'h07F8, 16'h0000, 2'd0, 8'h7F, 8'h00, 0, 0);
        idle(4);
        chk("sticky_ovf", 64'(sticky_o), 64'd1);
        clr_pulse();

        // Sticky lags sat_o by one cycle
        issue(16'h0000, 16'h8000, 2'd0, 8'h00, NEG_CLIP, 0, 1);
        valid_i = 1'b0;
        wait_valid(ok);
        if (ok) begin
            chk("sticky_same_cycle", 64'(sticky_o), 64'd0);
            @(negedge clk);
            chk("sticky_next_cycle", 64'(sticky_o), 64'd2);
        end
        @(posedge clk); #1;

`ifdef SAT_ROUND_PIPE_STATS_EN
        clr_pulse();
        for (int i = 0; i < 300; i++)
            issue(16'h0010, 16'h7FFF, 2'd0, 8'h01, 8'h7F, 0, 1);
        idle(4);
        chk("cnt_ch1_stuck", 64'(sat_cnt_o[15:8]), 64'd255);
        chk("cnt_ch0_zero", 64'(sat_cnt_o[7:0]), 64'd0);
`else
        chk("cnt_tied_zero", 64'(sat_cnt_o), 64'd0);
`endif

        // clr_i coincident with a saturated output
        issue(16'h0000, 16'h7FFF, 2'd0, 8'h00, 8'h7F, 0, 1);
        valid_i = 1'b0;
        wait_valid(ok);
        if (ok) begin
            clr_i = 1'b1;
            @(negedge clk);
            clr_i = 1'b0;
            chk("clr_wins_sticky", 64'(sticky_o), 64'd0);
            chk("clr_wins_cnt", 64'(sat_cnt_o), 64'd0);
        end
        @(posedge clk); #1;
        issue(16'h8000, 16'h0000, 2'd0, NEG_CLIP, 8'h00, 1, 0);
        idle(4);
        chk("sticky_before_reset", 64'(sticky_o), 64'd1);

        // Ramp with reset mid-stream
        for (int i = 1; i <= 8; i++) begin
            logic [15:0] v;
            logic [15:0] nv;
            v  = 16'(i) << 4;
            nv = -v;
            issue(v, nv, 2'd0, 8'(i), 8'(-i), 0, 0);
            if (i == 5) break;
        end
        rst_n = 1'b0;
        valid_i = 1'b0;
        q.delete();
        #1;
        chk("reset_valid_o", 64'(valid_o), 64'd0);
        chk("reset_y_o", 64'(y_o), 64'd0);
        chk("reset_sticky_o", 64'(sticky_o), 64'd0);
        seen = nout;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(6);
        chk("no_output_after_release", 64'(nout), 64'(seen));
        for (int i = 1; i <= 4; i++) begin
            logic [15:0] v;
            v = 16'(i) << 4;
            issue(v, 16'h7FF0, 2'd1, 8'(i), 8'h7F, 0, 1);
        end
        idle(4);
        chk("outputs_after_restart", 64'(nout), 64'(seen + 4));
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
